// File: rtl/intersection_pkg.sv
// ============================================================================
// Module   : intersection_pkg
// Brief    : Phase encoding, direction encoding and phase-duration lookup
// Revision : 1.0
// ============================================================================
`default_nettype none

package intersection_pkg;

  localparam int unsigned c_PHASE_W = 3;

  localparam logic [2:0] c_AR_A = 3'd0;
  localparam logic [2:0] c_A_G  = 3'd1;
  localparam logic [2:0] c_A_Y  = 3'd2;
  localparam logic [2:0] c_AR_B = 3'd3;
  localparam logic [2:0] c_B_G  = 3'd4;
  localparam logic [2:0] c_B_Y  = 3'd5;
  localparam logic [2:0] c_WALK = 3'd6;

  localparam logic c_DIR_A = 1'b0;
  localparam logic c_DIR_B = 1'b1;

  function automatic int unsigned phase_dur(
    input logic [2:0]  ph,
    input int unsigned green_t,
    input int unsigned yellow_t,
    input int unsigned allred_t,
    input int unsigned walk_t
  );
    case (ph)
      c_A_G, c_B_G: phase_dur = green_t;
      c_A_Y, c_B_Y: phase_dur = yellow_t;
      c_WALK:       phase_dur = walk_t;
      default:      phase_dur = allred_t;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/intersection_ctrl_phase_timer.sv
// ============================================================================
// Module   : phase_timer
// Brief    : Up-counter with synchronous clear and terminal-count flag
// Revision : 1.0
// ============================================================================
`default_nettype none

module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic [CNT_W-1:0] tc_val,
  output logic             term
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign term = (r_cnt == tc_val);

endmodule

`default_nettype wire

// File: rtl/intersection_ctrl.sv
// ============================================================================
// Module   : intersection_ctrl
// Brief    : Two-way intersection sequencer with all-red clearance and WALK
// Revision : 1.0
// ============================================================================
`default_nettype none

module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 27,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ped_req,
  output logic       a_green,
  output logic       a_yellow,
  output logic       a_red,
  output logic       b_green,
  output logic       b_yellow,
  output logic       b_red,
  output logic       walk,
  output logic [2:0] phase
);

  logic [2:0]       r_phase;
  logic             r_next_dir;
  logic             r_ped_pending;

  logic [2:0]       w_next_phase;
  logic             w_next_dir;
  logic             w_req;
  logic             w_term;
  logic             w_enter_walk;
  logic [CNT_W-1:0] w_tc_val;

  // Durations are 1..2^CNT_W, so the terminal count T-1 always fits CNT_W bits.
  assign w_tc_val = CNT_W'(phase_dur(r_phase, GREEN_T, YELLOW_T, ALLRED_T, WALK_T) - 1);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (w_term),
    .tc_val (w_tc_val),
    .term   (w_term)
  );

  assign w_req = r_ped_pending | ped_req;

  always_comb begin
    w_next_phase = r_phase;
    w_next_dir   = r_next_dir;
    if (w_term) begin
      case (r_phase)
        c_AR_A: begin
          if (w_req) begin
            w_next_phase = c_WALK;
            w_next_dir   = c_DIR_A;
          end else begin
            w_next_phase = c_A_G;
          end
        end
        c_A_G: w_next_phase = c_A_Y;
        c_A_Y: w_next_phase = c_AR_B;
        c_AR_B: begin
          if (w_req) begin
            w_next_phase = c_WALK;
            w_next_dir   = c_DIR_B;
          end else begin
            w_next_phase = c_B_G;
          end
        end
        c_B_G: w_next_phase = c_B_Y;
        c_B_Y: w_next_phase = c_AR_A;
        c_WALK: w_next_phase = (r_next_dir == c_DIR_A) ? c_A_G : c_B_G;
        default: w_next_phase = c_AR_A;
      endcase
    end
  end

  assign w_enter_walk = (w_next_phase == c_WALK) && (r_phase != c_WALK);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase       <= c_AR_A;
      r_next_dir    <= c_DIR_A;
      r_ped_pending <= 1'b0;
    end else begin
      r_phase    <= w_next_phase;
      r_next_dir <= w_next_dir;
      if (w_enter_walk) begin
        r_ped_pending <= 1'b0;
      end else if (ped_req && (r_phase != c_WALK)) begin
        r_ped_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    a_green  = 1'b0;
    a_yellow = 1'b0;
    a_red    = 1'b1;
    b_green  = 1'b0;
    b_yellow = 1'b0;
    b_red    = 1'b1;
    walk     = 1'b0;
    case (r_phase)
      c_A_G: begin a_green  = 1'b1; a_red = 1'b0; end
      c_A_Y: begin a_yellow = 1'b1; a_red = 1'b0; end
      c_B_G: begin b_green  = 1'b1; b_red = 1'b0; end
      c_B_Y: begin b_yellow = 1'b1; b_red = 1'b0; end
      c_WALK: walk = 1'b1;
      default: ;
    endcase
  end

  assign phase = r_phase;

endmodule

`default_nettype wire

// File: tb/tb_intersection_ctrl.sv
// ============================================================================
// Module   : tb_intersection_ctrl
// Brief    : Directed self-checking bench for intersection_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_intersection_ctrl;

  logic       clk;
  logic       rstn;
  logic       ped_req;

  logic       a_green, a_yellow, a_red, b_green, b_yellow, b_red, walk;
  logic [2:0] phase;
  logic       a_green2, a_yellow2, a_red2, b_green2, b_yellow2, b_red2, walk2;
  logic [2:0] phase2;
  logic       ped_req2;

  int checks;
  int errors;

  localparam logic [2:0] AR_A = 3'd0, A_G = 3'd1, A_Y = 3'd2, AR_B = 3'd3,
                         B_G  = 3'd4, B_Y = 3'd5, WLK = 3'd6;

  intersection_ctrl u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .ped_req  (ped_req),
    .a_green  (a_green),
    .a_yellow (a_yellow),
    .a_red    (a_red),
    .b_green  (b_green),
    .b_yellow (b_yellow),
    .b_red    (b_red),
    .walk     (walk),
    .phase    (phase)
  );

  intersection_ctrl #(
    .GREEN_T  (1),
    .YELLOW_T (1),
    .ALLRED_T (1)
  ) u_dut_fast (
    .clk      (clk),
    .rstn     (rstn),
    .ped_req  (ped_req2),
    .a_green  (a_green2),
    .a_yellow (a_yellow2),
    .a_red    (a_red2),
    .b_green  (b_green2),
    .b_yellow (b_yellow2),
    .b_red    (b_red2),
    .walk     (walk2),
    .phase    (phase2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {a_green, a_yellow, a_red, b_green, b_yellow, b_red, walk}
  function automatic logic [6:0] exp_lamps(input logic [2:0] ph);
    case (ph)
      A_G:     exp_lamps = 7'b100_001_0;
      A_Y:     exp_lamps = 7'b010_001_0;
      B_G:     exp_lamps = 7'b001_100_0;
      B_Y:     exp_lamps = 7'b001_010_0;
      WLK:     exp_lamps = 7'b001_001_1;
      default: exp_lamps = 7'b001_001_0;
    endcase
  endfunction

  always @(negedge clk) begin
    check("safety_main",
          {31'd0, ((a_green | a_yellow) & (b_green | b_yellow)) | (walk & ~(a_red & b_red))}, 32'd0);
    check("safety_fast",
          {31'd0, ((a_green2 | a_yellow2) & (b_green2 | b_yellow2)) | (walk2 & ~(a_red2 & b_red2))}, 32'd0);
  end

  task automatic run_phase(input bit fast, input string tag, input logic [2:0] ph, input int n);
    for (int i = 0; i < n; i++) begin
      if (!fast) begin
        check(tag, {29'd0, phase}, {29'd0, ph});
        check({tag, "_lamps"},
              {25'd0, a_green, a_yellow, a_red, b_green, b_yellow, b_red, walk},
              {25'd0, exp_lamps(ph)});
      end else begin
        check(tag, {29'd0, phase2}, {29'd0, ph});
        check({tag, "_lamps"},
              {25'd0, a_green2, a_yellow2, a_red2, b_green2, b_yellow2, b_red2, walk2},
              {25'd0, exp_lamps(ph)});
      end
      @(negedge clk);
    end
  endtask

  // Leaves the bench on a negedge with rstn just released: cycle 0 of AR_A.
  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_phase", {29'd0, phase}, 32'd0);
    check("rst_lamps", {25'd0, a_green, a_yellow, a_red, b_green, b_yellow, b_red, walk},
          {25'd0, 7'b001_001_0});
    rstn = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rstn     = 1'b0;
    ped_req  = 1'b0;
    ped_req2 = 1'b0;

    // Nominal sequence, no requests
    do_reset();
    run_phase(0, "nom_ar_a", AR_A, 2);
    run_phase(0, "nom_a_g",  A_G, 27);
    run_phase(0, "nom_a_y",  A_Y, 3);
    run_phase(0, "nom_ar_b", AR_B, 2);
    run_phase(0, "nom_b_g",  B_G, 27);
    run_phase(0, "nom_b_y",  B_Y, 3);
    run_phase(0, "nom_ar_a2", AR_A, 2);
    run_phase(0, "nom_a_g2", A_G, 1);

    // One-cycle request at absolute cycle 10 (inside A_G)
    do_reset();
    run_phase(0, "p1_ar_a", AR_A, 2);
    run_phase(0, "p1_a_g",  A_G, 8);
    ped_req = 1'b1;
    run_phase(0, "p1_a_g",  A_G, 1);
    ped_req = 1'b0;
    run_phase(0, "p1_a_g",  A_G, 18);
    run_phase(0, "p1_a_y",  A_Y, 3);
    run_phase(0, "p1_ar_b", AR_B, 2);
    run_phase(0, "p1_walk", WLK, 10);
    run_phase(0, "p1_b_g",  B_G, 27);
    run_phase(0, "p1_b_y",  B_Y, 3);
    run_phase(0, "p1_ar_a", AR_A, 2);
    run_phase(0, "p1_a_g2", A_G, 1);

    // Request held for cycles 0..99
    do_reset();
    ped_req = 1'b1;
    run_phase(0, "hold_ar_a",  AR_A, 2);
    run_phase(0, "hold_walk1", WLK, 10);
    run_phase(0, "hold_a_g",   A_G, 27);
    run_phase(0, "hold_a_y",   A_Y, 3);
    run_phase(0, "hold_ar_b",  AR_B, 2);
    run_phase(0, "hold_walk2", WLK, 10);
    run_phase(0, "hold_b_g",   B_G, 27);
    run_phase(0, "hold_b_y",   B_Y, 3);
    run_phase(0, "hold_ar_a2", AR_A, 2);
    run_phase(0, "hold_walk3", WLK, 10);
    run_phase(0, "hold_a_g2",  A_G, 4);
    ped_req = 1'b0;
    run_phase(0, "hold_a_g2",  A_G, 23);
    run_phase(0, "hold_a_y2",  A_Y, 3);
    run_phase(0, "hold_ar_b2", AR_B, 2);
    run_phase(0, "hold_walk4", WLK, 10);
    run_phase(0, "hold_b_g2",  B_G, 27);
    run_phase(0, "hold_b_y2",  B_Y, 3);
    run_phase(0, "hold_ar_a3", AR_A, 2);
    run_phase(0, "hold_a_g3",  A_G, 1);

    // Request only on the terminal cycle of AR_A
    do_reset();
    run_phase(0, "last_ar_a", AR_A, 1);
    ped_req = 1'b1;
    run_phase(0, "last_ar_a", AR_A, 1);
    ped_req = 1'b0;
    run_phase(0, "last_walk", WLK, 10);
    run_phase(0, "last_a_g",  A_G, 27);
    run_phase(0, "last_a_y",  A_Y, 3);
    run_phase(0, "last_ar_b", AR_B, 2);
    run_phase(0, "last_b_g",  B_G, 1);

    // Asynchronous reset mid-B_G with a request pending
    do_reset();
    run_phase(0, "ar_ar_a", AR_A, 2);
    run_phase(0, "ar_a_g",  A_G, 27);
    run_phase(0, "ar_a_y",  A_Y, 3);
    run_phase(0, "ar_ar_b", AR_B, 2);
    run_phase(0, "ar_b_g",  B_G, 5);
    ped_req = 1'b1;
    run_phase(0, "ar_b_g",  B_G, 1);
    ped_req = 1'b0;
    run_phase(0, "ar_b_g",  B_G, 2);
    #2 rstn = 1'b0;
    #1;
    check("async_phase", {29'd0, phase}, 32'd0);
    check("async_lamps", {25'd0, a_green, a_yellow, a_red, b_green, b_yellow, b_red, walk},
          {25'd0, 7'b001_001_0});
    @(negedge clk);
    rstn = 1'b1;
    run_phase(0, "post_ar_a", AR_A, 2);
    run_phase(0, "post_a_g",  A_G, 27);
    run_phase(0, "post_a_y",  A_Y, 3);
    run_phase(0, "post_ar_b", AR_B, 2);
    run_phase(0, "post_b_g",  B_G, 1);

    // Minimum-duration instance: 6-cycle period
    do_reset();
    for (int k = 0; k < 2; k++) begin
      run_phase(1, "fast_ar_a", AR_A, 1);
      run_phase(1, "fast_a_g",  A_G, 1);
      run_phase(1, "fast_a_y",  A_Y, 1);
      run_phase(1, "fast_ar_b", AR_B, 1);
      run_phase(1, "fast_b_g",  B_G, 1);
      run_phase(1, "fast_b_y",  B_Y, 1);
    end
    run_phase(1, "fast_ar_a2", AR_A, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
